// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port.
// Grant is held until the memory completes; a watchdog forces an error completion on a hung access.
module dmem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [3:0]            m0_we_i,
    output logic                  m0_ready_o,
    output logic                  m0_err_o,
    input  logic                  m1_valid_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [3:0]            m1_we_i,
    output logic                  m1_ready_o,
    output logic                  m1_err_o,
    output logic [DATA_WIDTH-1:0] m_rdata_o,
    output logic                  dmem_valid_o,
    input  logic                  dmem_ready_i,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_we_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                   WDOG_EN     = (TIMEOUT_CYCLES != 0);

    state_t                 state_reg, state_next;
    logic                   owner_reg, owner_next;
    logic                   ptr_reg, ptr_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic [1:0]             req_valid;
    logic [ADDR_WIDTH-1:0]  req_addr  [2];
    logic [DATA_WIDTH-1:0]  req_wdata [2];
    logic [3:0]             req_we    [2];
    logic [1:0]             ready_vec;
    logic [1:0]             err_vec;
    logic                   sel;
    logic                   mem_valid;
    logic                   we_pass;
    logic                   timeout_hit;

    assign req_valid    = {m1_valid_i, m0_valid_i};
    assign req_addr[0]  = m0_addr_i;
    assign req_addr[1]  = m1_addr_i;
    assign req_wdata[0] = m0_wdata_i;
    assign req_wdata[1] = m1_wdata_i;
    assign req_we[0]    = m0_we_i;
    assign req_we[1]    = m1_we_i;

    assign timeout_hit = WDOG_EN && (cnt_reg == TIMEOUT_CNT);

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        sel        = 1'b0;
        mem_valid  = 1'b0;
        we_pass    = 1'b0;
        ready_vec  = 2'b00;
        err_vec    = 2'b00;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    sel       = (&req_valid) ? ptr_reg : req_valid[1];
                    mem_valid = 1'b1;
                    we_pass   = 1'b1;
                    if (dmem_ready_i) begin
                        ready_vec[sel] = 1'b1;
                        ptr_next       = ~sel;
                    end else begin
                        state_next = BUSY;
                        owner_next = sel;
                        // The grant cycle already waited once on the memory, so it counts.
                        cnt_next   = CNT_WIDTH'(1);
                    end
                end
            end
            BUSY: begin
                sel       = owner_reg;
                mem_valid = 1'b1;
                we_pass   = 1'b1;
                if (dmem_ready_i) begin
                    ready_vec[sel] = 1'b1;
                    state_next     = IDLE;
                    cnt_next       = '0;
                    ptr_next       = ~sel;
                end else if (timeout_hit) begin
                    ready_vec[sel] = 1'b1;
                    err_vec[sel]   = 1'b1;
                    mem_valid      = 1'b0;
                    state_next     = IDLE;
                    cnt_next       = '0;
                    ptr_next       = ~sel;
                end else if (WDOG_EN) begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            ptr_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Strobes are masked during reset so an abandoned transaction never completes.
    assign dmem_valid_o = mem_valid & ~rst;
    assign m0_ready_o   = ready_vec[0] & ~rst;
    assign m1_ready_o   = ready_vec[1] & ~rst;
    assign m0_err_o     = err_vec[0] & ~rst;
    assign m1_err_o     = err_vec[1] & ~rst;
    assign dmem_addr_o  = req_addr[sel];
    assign dmem_wdata_o = req_wdata[sel];
    assign dmem_we_o    = we_pass ? req_we[sel] : 4'b0000;
    assign m_rdata_o    = dmem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenario table followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
    logic [3:0]  we0 = '0, we1 = '0;
    logic        rdy = 1'b0;
    logic [31:0] rdata = '0;

    logic        m0_ready, m0_err, m1_ready, m1_err, dmem_valid;
    logic [31:0] m_rdata, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_we;

    dmem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_valid_i(v0), .m0_addr_i(a0), .m0_wdata_i(d0), .m0_we_i(we0),
        .m0_ready_o(m0_ready), .m0_err_o(m0_err),
        .m1_valid_i(v1), .m1_addr_i(a1), .m1_wdata_i(d1), .m1_we_i(we1),
        .m1_ready_o(m1_ready), .m1_err_o(m1_err),
        .m_rdata_o(m_rdata),
        .dmem_valid_o(dmem_valid), .dmem_ready_i(rdy),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_we_o(dmem_we),
        .dmem_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: who holds the memory (-1 none), when it was granted, who is favoured.
    int cur = -1;
    int grant_cyc = 0;
    int fav = 0;
    bit seen0 = 0, seen1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        logic ev, er0, er1, ee0, ee1, data_chk, idle_chk;
        int w;
        ev = 0; er0 = 0; er1 = 0; ee0 = 0; ee1 = 0; data_chk = 0; idle_chk = 0; w = 0;
        if (rst) begin
            cur = -1; fav = 0;
        end else if (cur < 0) begin
            if (v0 || v1) begin
                w = (v0 && v1) ? fav : (v1 ? 1 : 0);
                ev = 1; data_chk = 1;
                if (rdy) begin
                    if (w == 0) er0 = 1; else er1 = 1;
                    fav = 1 - w;
                end else begin
                    cur = w; grant_cyc = cyc;
                end
            end else begin
                idle_chk = 1;
            end
        end else begin
            w = cur;
            if (rdy) begin
                ev = 1; data_chk = 1;
                if (w == 0) er0 = 1; else er1 = 1;
                fav = 1 - w; cur = -1;
            end else if (cyc - grant_cyc == TO) begin
                if (w == 0) begin er0 = 1; ee0 = 1; end else begin er1 = 1; ee1 = 1; end
                fav = 1 - w; cur = -1;
            end else begin
                ev = 1; data_chk = 1;
            end
        end
        check_eq("dmem_valid", 32'(dmem_valid), 32'(ev));
        check_eq("m0_ready", 32'(m0_ready), 32'(er0));
        check_eq("m1_ready", 32'(m1_ready), 32'(er1));
        check_eq("m0_err", 32'(m0_err), 32'(ee0));
        check_eq("m1_err", 32'(m1_err), 32'(ee1));
        check_eq("m_rdata", m_rdata, rdata);
        if (data_chk) begin
            check_eq("dmem_addr", dmem_addr, (w == 0) ? a0 : a1);
            check_eq("dmem_wdata", dmem_wdata, (w == 0) ? d0 : d1);
            check_eq("dmem_we", 32'(dmem_we), 32'((w == 0) ? we0 : we1));
        end
        if (idle_chk) begin
            check_eq("idle_addr", dmem_addr, a0);
            check_eq("idle_we", 32'(dmem_we), 32'h0);
        end
        seen0 = er0; seen1 = er1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Masters drop valid after their ready and may immediately issue a new request.
    task automatic masters(input bit s0, input bit s1);
        if (seen0) v0 = 1'b0;
        if (seen1) v1 = 1'b0;
        seen0 = 0; seen1 = 0;
        if (!v0 && s0) begin
            v0 = 1'b1; a0 = $urandom; d0 = $urandom; we0 = 4'($urandom_range(0, 15));
        end
        if (!v1 && s1) begin
            v1 = 1'b1; a1 = $urandom; d1 = $urandom; we1 = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic apply(input bit r, input bit s0, input bit s1, input bit mr);
        rst = r;
        if (r) begin
            v0 = 1'b0; v1 = 1'b0; seen0 = 0; seen1 = 0;
        end else begin
            masters(s0, s1);
        end
        rdy = mr;
        rdata = $urandom;
        cycle();
    endtask

    // Rows are {rst, start0, start1, mem_ready}.
    logic [3:0] script [] = '{
        4'b1000, 4'b1000,
        4'b0110, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0000,
        4'b0011, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
        4'b0010, 4'b0000, 4'b1000, 4'b0110, 4'b0001, 4'b0000
    };

    initial begin
        logic [3:0] row;
        int pct;
        for (int i = 0; i < script.size(); i++) begin
            row = script[i];
            apply(row[3], row[2], row[1], row[0]);
        end
        for (int i = 0; i < 3000; i++) begin
            case ((i / 64) % 3)
                0: pct = 70;
                1: pct = 25;
                default: pct = 3;
            endcase
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) < pct);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter sharing the single data-memory port between the LSU (master 0) and a second requester (master 1, debug/DMA port).
- Sits between the requesters' dmem valid/ready interfaces and the data memory.
- Round-robin fair arbitration; grant locked until the memory completes.
- Per-transaction watchdog terminates a hung access with an error.

Parameters:
- ADDR_WIDTH, 32, address width (RISCV_ADDR_WIDTH)
- DATA_WIDTH, 32, data width (RISCV_WORD_WIDTH)
- TIMEOUT_CYCLES, 255, cycles in BUSY without dmem_ready_i before forced error completion; 0 disables watchdog
- CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- m0_valid_i  in  1  master 0 request
- m0_addr_i  in  ADDR_WIDTH  master 0 address
- m0_wdata_i  in  DATA_WIDTH  master 0 write data
- m0_we_i  in  4  master 0 byte write enables; 0 means read
- m0_ready_o  out  1  master 0 completion strobe
- m0_err_o  out  1  master 0 error, valid with m0_ready_o
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_ready_o, m1_err_o  as m0, for master 1
- m_rdata_o  out  DATA_WIDTH  read data broadcast to both masters; qualify with own ready
- dmem_valid_o  out  1  memory request
- dmem_ready_i  in  1  memory completion; dmem_rdata_i valid in same cycle
- dmem_addr_o  out  ADDR_WIDTH
- dmem_wdata_o  out  DATA_WIDTH
- dmem_we_o  out  4
- dmem_rdata_i  in  DATA_WIDTH

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Master protocol: a master holds valid/addr/wdata/we stable until it sees its own ready for one cycle.
- State: IDLE and BUSY, plus owner register (0/1), priority pointer (favoured master) and watchdog counter.
- Reset values: state IDLE, owner 0, pointer favours m0, counter 0.
- Reset outputs: dmem_valid_o 0, m0/m1_ready_o 0, m0/m1_err_o 0.
- Reset mid-transaction: the transaction is abandoned and no ready is issued.
- IDLE arbitration (combinational, same cycle):
  - Only one valid: that master wins.
  - Both valid: the pointer's master wins.
  - Winner's addr/wdata/we are muxed to dmem_*; dmem_valid_o = 1.
- IDLE completion: if dmem_ready_i is also high (zero-wait memory), the transaction completes this cycle, state stays IDLE and the pointer updates.
- IDLE otherwise: the winner is latched into owner and state goes to BUSY.
- IDLE, no valid: dmem_valid_o 0; dmem_addr_o/wdata_o follow m0 inputs; dmem_we_o 0.
- BUSY:
  - dmem_valid_o held 1 and dmem_* muxed from the owner, even if the owner illegally drops valid.
  - The other master's valid is ignored; no preemption.
- Completion: dmem_ready_i high -> owner's ready_o = 1 for that cycle, err_o 0, m_rdata_o = dmem_rdata_i. Then: state -> IDLE, counter -> 0, pointer -> the non-owner.
- Next grant: evaluated in the cycle after completion; no back-to-back grant in the completion cycle from BUSY.
- Watchdog:
  - Counter increments each BUSY cycle without dmem_ready_i.
  - When counter == TIMEOUT_CYCLES and dmem_ready_i is low: owner ready_o = 1 and err_o = 1 for one cycle, dmem_valid_o driven 0 that cycle, state -> IDLE, pointer rotates.
  - dmem_ready_i coincident with the timeout cycle: normal completion wins, err_o 0.
- Non-owner ready_o/err_o: always 0.
- m_rdata_o: equals dmem_rdata_i at all times.
- Writes: dmem_we_o passes the owner's byte enables unchanged; no shifting or alignment here.

Test Plan:
- Single read, m0 only: m0 addr 0x100, we 0; memory returns ready 2 cycles later with 0xDEADBEEF -> dmem_addr_o 0x100 throughout, m0_ready_o one cycle with m_rdata_o 0xDEADBEEF, m1_ready_o 0.
- Simultaneous requests, fresh reset: m0 and m1 both valid, memory 1-wait -> m0 served first, then m1 (pointer rotated); m0 re-requests while m1 owns -> m0 waits, served after m1.
- Zero-wait write: m1 write 0x12345678, we 4'b1111, dmem_ready_i high in the request cycle -> m1_ready_o same cycle, state stays IDLE, next tie goes to m0.
- Timeout: TIMEOUT_CYCLES=4, memory never ready -> m0_ready_o and m0_err_o high exactly 4 BUSY cycles after grant, dmem_valid_o low that cycle, arbiter then grants pending m1.
- Ready coincident with timeout: ready arrives on cycle 4 -> err_o 0, normal completion.
- Reset mid-BUSY: assert rst while m1 owns -> next cycle dmem_valid_o 0, no ready to m1, pointer favours m0.
